// File: rtl/r200_pkg.sv
// r200_pkg: shared constants and helpers for the r200 single-cycle core.
//   - RV32I opcode, funct3 and funct7 constants for the supported subset
//   - ALU operation and writeback-source enums
//   - f3_op(): maps funct3 to its base (funct7 = 0) ALU operation
//   - alu(): the 32-bit ALU, wrap-around arithmetic, shift amount b[4:0]
package r200_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [2:0] F3_JALR = 3'd0;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {WB_ALU, WB_LINK, WB_LOAD} wb_sel_e;

    function automatic alu_op_e f3_op(input logic [2:0] f3);
        case (f3)
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

endpackage

// File: rtl/r200_imem.sv
// r200_imem: byte-wide instruction ROM, little-endian 32-bit combinational fetch.
//   addr  - byte address (already reduced modulo BYTES by the caller's slice)
//   instr - {ram[addr+3], ram[addr+2], ram[addr+1], ram[addr]}
// Byte addresses wrap inside the ROM, so a fetch straddling the end reads from 0.
// Contents are written hierarchically into ram by the environment.
module r200_imem #(
    parameter int    BYTES = 1024,
    parameter string FILE  = "curr.8b.hex"
) (
    input  logic [$clog2(BYTES)-1:0] addr,
    output logic [31:0]              instr
);
    localparam int AW = $clog2(BYTES);

    logic [7:0]    ram [BYTES];
    logic [AW-1:0] a1, a2, a3;

    assign a1    = addr + AW'(1);
    assign a2    = addr + AW'(2);
    assign a3    = addr + AW'(3);
    assign instr = {ram[a3], ram[a2], ram[a1], ram[addr]};

endmodule

// File: rtl/r200_core.sv
// r200_core: unpipelined single-cycle RV32I-subset core (OP, OP-IMM, LUI, AUIPC,
// JAL, JALR, branches, LW, SW). One instruction retires per rising clock edge.
//   clock       - rising-edge clock
//   pc_rst_n    - asynchronous active-low reset (pc, registers, halted)
//   dbg_pc      - PC of the instruction executing this cycle
//   dbg_wb_en   - a register write happens on the coming edge (never for x0)
//   dbg_wb_addr - destination register
//   dbg_wb_data - writeback value
//   halted      - stopped on an illegal instruction
// Build option R200_ILLEGAL_HALT_EN: an illegal instruction freezes the core and
// sets halted until reset. Without it illegal instructions act as NOPs.
module r200_core
    import r200_pkg::*;
#(
    parameter int    IMEM_BYTES = 1024,
    parameter int    DMEM_WORDS = 256,
    parameter string IMEM_FILE  = "curr.8b.hex"
) (
    input  logic        clock,
    input  logic        pc_rst_n,
    output logic [31:0] dbg_pc,
    output logic        dbg_wb_en,
    output logic [4:0]  dbg_wb_addr,
    output logic [31:0] dbg_wb_data,
    output logic        halted
);
    localparam int IAW = $clog2(IMEM_BYTES);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0]       pc, instr;
    logic [31:0][31:0] regs;
    logic [31:0]       dmem [DMEM_WORDS];

    r200_imem #(.BYTES(IMEM_BYTES), .FILE(IMEM_FILE)) instrnmem (
        .addr  (pc[IAW-1:0]),
        .instr (instr)
    );

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1v, rs2v, link, mem_addr, load_data, alu_y, wb_data, next_pc;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // regs[0] is reset to zero and never written, so x0 reads 0 directly.
    assign rs1v = regs[rs1];
    assign rs2v = regs[rs2];
    assign link = pc + 32'd4;

    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    logic [31:0] alu_a, alu_b, tgt_raw;
    logic        rd_we, mem_we, jump, illegal;

    always_comb begin
        alu_op  = ALU_ADD;
        alu_a   = rs1v;
        alu_b   = rs2v;
        wb_sel  = WB_ALU;
        rd_we   = 1'b0;
        mem_we  = 1'b0;
        jump    = 1'b0;
        tgt_raw = pc + imm_b;
        illegal = 1'b0;
        case (opcode)
            OP: begin
                rd_we = 1'b1;
                if (funct7 == F7_BASE)                         alu_op = f3_op(funct3);
                else if (funct7 == F7_ALT && funct3 == F3_ADD) alu_op = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == F3_SR)  alu_op = ALU_SRA;
                else                                           illegal = 1'b1;
            end
            OP_IMM: begin
                rd_we  = 1'b1;
                alu_b  = imm_i;
                alu_op = f3_op(funct3);
                // Shift-immediates reuse imm[11:5] as funct7.
                if (funct3 == F3_SLL && funct7 != F7_BASE) illegal = 1'b1;
                else if (funct3 == F3_SR) begin
                    if (funct7 == F7_ALT)       alu_op  = ALU_SRA;
                    else if (funct7 != F7_BASE) illegal = 1'b1;
                end
            end
            LUI: begin
                rd_we = 1'b1;
                alu_a = 32'd0;
                alu_b = imm_u;
            end
            AUIPC: begin
                rd_we = 1'b1;
                alu_a = pc;
                alu_b = imm_u;
            end
            JAL: begin
                rd_we   = 1'b1;
                wb_sel  = WB_LINK;
                jump    = 1'b1;
                tgt_raw = pc + imm_j;
            end
            JALR: begin
                if (funct3 != F3_JALR) illegal = 1'b1;
                rd_we   = 1'b1;
                wb_sel  = WB_LINK;
                jump    = 1'b1;
                tgt_raw = rs1v + imm_i;
            end
            BRANCH: begin
                case (funct3)
                    F3_BEQ:  jump = (rs1v == rs2v);
                    F3_BNE:  jump = (rs1v != rs2v);
                    F3_BLT:  jump = ($signed(rs1v) < $signed(rs2v));
                    F3_BGE:  jump = ($signed(rs1v) >= $signed(rs2v));
                    F3_BLTU: jump = (rs1v < rs2v);
                    F3_BGEU: jump = (rs1v >= rs2v);
                    default: illegal = 1'b1;
                endcase
            end
            LOAD: begin
                if (funct3 == F3_W) begin
                    rd_we  = 1'b1;
                    wb_sel = WB_LOAD;
                end else illegal = 1'b1;
            end
            STORE: begin
                if (funct3 == F3_W) mem_we = 1'b1;
                else                illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_y = alu(alu_op, alu_a, alu_b);

    // Word-aligned targets: bit0 (JALR) and bit1 are both cleared, no trap.
    assign next_pc = (jump && !illegal) ? {tgt_raw[31:2], 2'b00} : link;

    logic unused_addr;
    assign mem_addr    = rs1v + ((opcode == STORE) ? imm_s : imm_i);
    assign unused_addr = ^{mem_addr[31:DAW+2], mem_addr[1:0]};
    assign load_data   = dmem[mem_addr[DAW+1:2]];

    always_comb begin
        case (wb_sel)
            WB_LINK: wb_data = link;
            WB_LOAD: wb_data = load_data;
            default: wb_data = alu_y;
        endcase
    end

    logic freeze, commit, wb_en;

`ifdef R200_ILLEGAL_HALT_EN
    logic halt_q;
    always_ff @(posedge clock or negedge pc_rst_n) begin
        if (!pc_rst_n)    halt_q <= 1'b0;
        else if (illegal) halt_q <= 1'b1;
    end
    assign freeze = illegal | halt_q;
    assign halted = halt_q;
`else
    assign freeze = 1'b0;
    assign halted = 1'b0;
`endif

    // Nothing architectural changes while in reset or on an illegal instruction.
    assign commit = pc_rst_n & ~illegal & ~freeze;
    assign wb_en  = commit & rd_we & (rd != 5'd0);

    always_ff @(posedge clock or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            pc   <= RESET_PC;
            regs <= '0;
        end else begin
            if (!freeze) pc <= next_pc;
            if (wb_en)   regs[rd] <= wb_data;
        end
    end

    // Data RAM is not reset; the commit gate keeps stores out during reset.
    always_ff @(posedge clock) begin
        if (commit && mem_we) dmem[mem_addr[DAW+1:2]] <= rs2v;
    end

    assign dbg_pc      = pc;
    assign dbg_wb_en   = wb_en;
    assign dbg_wb_addr = rd;
    assign dbg_wb_data = wb_data;

endmodule

// File: tb/tb_r200_core.sv
// tb_r200_core: directed program for r200_core. The program is poked into the
// instruction ROM while reset is held; each instruction's expected retirement
// (pc, write enable, rd, data, halted) is queued and compared cycle by cycle.
module tb_r200_core;
    logic        clock = 1'b0;
    logic        pc_rst_n;
    logic [31:0] dbg_pc;
    logic        dbg_wb_en;
    logic [4:0]  dbg_wb_addr;
    logic [31:0] dbg_wb_data;
    logic        halted;

    always #5 clock = ~clock;

    r200_core #(.IMEM_BYTES(1024), .DMEM_WORDS(256), .IMEM_FILE("")) dut (
        .clock       (clock),
        .pc_rst_n    (pc_rst_n),
        .dbg_pc      (dbg_pc),
        .dbg_wb_en   (dbg_wb_en),
        .dbg_wb_addr (dbg_wb_addr),
        .dbg_wb_data (dbg_wb_data),
        .halted      (halted)
    );

    typedef struct { logic [31:0] pc, wen, rd, data, hlt; } ret_t;
    ret_t sbq[$];
    ret_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Instruction encoders, written directly from the RV32I formats.
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input int opc);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'd2, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int opc);
        return {imm20[19:0], rd[4:0], opc[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic put(input int addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.instrnmem.ram[addr + k] = w[8*k +: 8];
    endtask

    task automatic exp_ret(input int pc, input int wen, input int rd,
                           input logic [31:0] data, input int hlt);
        ret_t r;
        r.pc   = pc;
        r.wen  = wen;
        r.rd   = rd;
        r.data = data;
        r.hlt  = hlt;
        sbq.push_back(r);
    endtask

    initial begin
        pc_rst_n = 1'b0;
        for (int a = 0; a < 1024; a++) dut.instrnmem.ram[a] = 8'h00;

        put(32'h00, enc_i(12, 0, 0, 3, 7'b0010011));           // addi x3,x0,12
        put(32'h04, enc_i(-20, 3, 0, 4, 7'b0010011));          // addi x4,x3,-20
        put(32'h08, enc_i(32'h401, 4, 5, 5, 7'b0010011));      // srai x5,x4,1
        put(32'h0C, enc_i(28, 4, 5, 6, 7'b0010011));           // srli x6,x4,28
        put(32'h10, enc_i(-1, 0, 0, 1, 7'b0010011));           // addi x1,x0,-1
        put(32'h14, enc_i(1, 0, 0, 2, 7'b0010011));            // addi x2,x0,1
        put(32'h18, enc_r(0, 2, 1, 2, 7));                     // slt  x7,x1,x2
        put(32'h1C, enc_r(0, 2, 1, 3, 8));                     // sltu x8,x1,x2
        put(32'h20, enc_j(16, 1));                             // jal  x1,+16
        put(32'h24, enc_u(32'h12345, 9, 7'b0110111));          // lui  x9,0x12345
        put(32'h28, enc_i(5, 0, 0, 0, 7'b0010011));            // addi x0,x0,5
        put(32'h2C, enc_b(8, 5, 2, 6));                        // bltu x2,x5,+8
        put(32'h30, enc_i(1, 1, 0, 0, 7'b1100111));            // jalr x0,1(x1)
        put(32'h34, enc_b(8, 2, 1, 0));                        // beq  x1,x2,+8
        put(32'h38, enc_s(8, 3, 0));                           // sw   x3,8(x0)
        put(32'h3C, enc_i(8, 0, 2, 10, 7'b0000011));           // lw   x10,8(x0)
        put(32'h40, 32'hFFFF_FFFF);                            // illegal
        put(32'h44, enc_r(0, 0, 3, 0, 11));                    // add  x11,x3,x0
        put(32'h48, enc_r(32, 3, 0, 0, 12));                   // sub  x12,x0,x3
        put(32'h4C, enc_r(0, 2, 1, 4, 13));                    // xor  x13,x1,x2
        put(32'h50, enc_j(0, 0));                              // jal  x0,0

        exp_ret(32'h00, 1, 3,  32'h0000_000C, 0);
        exp_ret(32'h04, 1, 4,  32'hFFFF_FFF8, 0);
        exp_ret(32'h08, 1, 5,  32'hFFFF_FFFC, 0);
        exp_ret(32'h0C, 1, 6,  32'h0000_000F, 0);
        exp_ret(32'h10, 1, 1,  32'hFFFF_FFFF, 0);
        exp_ret(32'h14, 1, 2,  32'h0000_0001, 0);
        exp_ret(32'h18, 1, 7,  32'h0000_0001, 0);
        exp_ret(32'h1C, 1, 8,  32'h0000_0000, 0);
        exp_ret(32'h20, 1, 1,  32'h0000_0024, 0);
        exp_ret(32'h30, 0, 0,  32'h0, 0);
        exp_ret(32'h24, 1, 9,  32'h1234_5000, 0);
        exp_ret(32'h28, 0, 0,  32'h0, 0);
        exp_ret(32'h2C, 0, 0,  32'h0, 0);
        exp_ret(32'h34, 0, 0,  32'h0, 0);
        exp_ret(32'h38, 0, 0,  32'h0, 0);
        exp_ret(32'h3C, 1, 10, 32'h0000_000C, 0);
        exp_ret(32'h40, 0, 0,  32'h0, 0);
`ifdef R200_ILLEGAL_HALT_EN
        for (int n = 0; n < 3; n++) exp_ret(32'h40, 0, 0, 32'h0, 1);
`else
        exp_ret(32'h44, 1, 11, 32'h0000_000C, 0);
        exp_ret(32'h48, 1, 12, 32'hFFFF_FFF4, 0);
        exp_ret(32'h4C, 1, 13, 32'h0000_0025, 0);
        exp_ret(32'h50, 0, 0,  32'h0, 0);
        exp_ret(32'h50, 0, 0,  32'h0, 0);
`endif

        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        chk("reset pc", dbg_pc, 32'h0);
        chk("reset wb_en", {31'b0, dbg_wb_en}, 32'h0);
        chk("reset halted", {31'b0, halted}, 32'h0);

        pc_rst_n = 1'b1;   // released mid-cycle
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("pc (exp %h)", e.pc), dbg_pc, e.pc);
            chk($sformatf("wb_en @%h", e.pc), {31'b0, dbg_wb_en}, e.wen);
            chk($sformatf("halted @%h", e.pc), {31'b0, halted}, e.hlt);
            if (e.wen[0]) begin
                chk($sformatf("wb_addr @%h", e.pc), {27'b0, dbg_wb_addr}, e.rd);
                chk($sformatf("wb_data @%h", e.pc), dbg_wb_data, e.data);
            end
            @(negedge clock); #1;
        end

        pc_rst_n = 1'b0;
        #1;
        chk("re-reset pc", dbg_pc, 32'h0);
        chk("re-reset wb_en", {31'b0, dbg_wb_en}, 32'h0);
        chk("re-reset halted", {31'b0, halted}, 32'h0);
        @(posedge clock); #1;
        chk("reset hold pc", dbg_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
